uart_tx_fifo: RTL and testbench

Buffered UART transmitter for the mips789 device controller. Accepts bytes from the memory-mapped byte store to the UART data address, queues them in a small FIFO and serialises them onto `ser_txd` as 8-N-1 frames. Its `txd_busy` output feeds the controller's status word so software polls it before each store.

---
 rtl/uart_tx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8-N-1 UART transmitter with a small byte FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit (8-E-1 frames).
module uart_tx_fifo #(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               txd_ld,
    input  logic [7:0]         din,
    output logic               txd_busy,
    output logic               txd_empty,
    output logic [FIFO_AW:0]   txd_level,
    output logic               ser_txd
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] LVL_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic [FIFO_AW:0]   level_nx;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic [2:0]  idx;
    logic [2:0]  idx_nx;
    logic [7:0]  tx_byte;
    logic [7:0]  tx_byte_nx;
    logic        txd_nx;

    logic push;
    logic pop;
    logic tick;

    assign push = txd_ld && !txd_busy;
    assign tick = (cnt == 16'd0);
    assign pop  = (level != '0) &&
                  ((state == S_IDLE) || ((state == S_STOP) && tick));

    assign txd_level = level;

    always_comb begin
        level_nx = level;
        if (push && !pop) begin
            level_nx = level + LVL_ONE;
        end else if (pop && !push) begin
            level_nx = level - LVL_ONE;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        tx_byte_nx = tx_byte;
        if (!tick) begin
            cnt_nx = cnt - 16'd1;
        end
        unique case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nx   = S_START;
                    cnt_nx     = DIV_M1;
                    tx_byte_nx = mem[rd_ptr];
                end
            end
            S_START: begin
                if (tick) begin
                    state_nx = S_DATA;
                    idx_nx   = 3'd0;
                    cnt_nx   = DIV_M1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_nx = DIV_M1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_nx = S_STOP;
                    cnt_nx   = DIV_M1;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (tick) begin
                    if (pop) begin
                        state_nx   = S_START;
                        cnt_nx     = DIV_M1;
                        tx_byte_nx = mem[rd_ptr];
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 16'd0;
            end
        endcase
    end

    // The line is registered from the next state so it changes with it.
    always_comb begin
        txd_nx = 1'b1;
        unique case (state_nx)
            S_START: txd_nx = 1'b0;
            S_DATA:  txd_nx = tx_byte_nx[idx_nx];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_nx = ^tx_byte_nx;
`endif
            default: txd_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            state     <= S_IDLE;
            cnt       <= 16'd0;
            idx       <= 3'd0;
            tx_byte   <= 8'd0;
            ser_txd   <= 1'b1;
            txd_busy  <= 1'b0;
            txd_empty <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level     <= level_nx;
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            tx_byte   <= tx_byte_nx;
            ser_txd   <= txd_nx;
            txd_busy  <= (level_nx == LVL_FULL);
            txd_empty <= (level_nx == '0) && (state_nx == S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized checks for uart_tx_fifo against a line-level UART model.
// Build with UART_TX_PARITY_EN defined to exercise the 8-E-1 frame.
module tb_uart_tx_fifo;

    localparam int DIV   = 4;
    localparam int AW    = 3;
`ifdef UART_TX_PARITY_EN
    localparam int NB    = 11;
`else
    localparam int NB    = 10;
`endif
    localparam int FR    = NB * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          txd_ld = 1'b0;
    logic [7:0]    din = 8'd0;
    logic          txd_busy;
    logic          txd_empty;
    logic [AW:0]   txd_level;
    logic          ser_txd;

    int checks = 0;
    int errors = 0;

    bit         line_log[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         n0;
    int         p0;
    int         nbad;
    int         guard;
    logic [7:0] rb;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_DIV(DIV),
        .FIFO_AW(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .txd_ld   (txd_ld),
        .din      (din),
        .txd_busy (txd_busy),
        .txd_empty(txd_empty),
        .txd_level(txd_level),
        .ser_txd  (ser_txd)
    );

    task automatic step();
        @(posedge clk);
        #1;
        line_log.push_back(ser_txd);
    endtask

    function automatic int now();
        return line_log.size() - 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] b);
        txd_ld = 1'b1;
        din    = b;
        step();
        txd_ld = 1'b0;
    endtask

    // Ideal UART line value for frame bit i of byte b.
    function automatic logic line_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic [63:0] frame_exp(input logic [7:0] b);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < FR; i++) v[i] = line_bit(b, i / DIV);
        return v;
    endfunction

    task automatic frames_at(input int start, input logic [7:0] bytes[$],
                             input string tag);
        logic [63:0] v;
        while (line_log.size() < start + bytes.size() * FR) step();
        foreach (bytes[j]) begin
            v = '0;
            for (int i = 0; i < FR; i++) v[i] = line_log[start + j*FR + i];
            chk($sformatf("%s_frame%0d", tag, j), v, frame_exp(bytes[j]));
        end
    endtask

    task automatic idle_for(input int from, input int len, input string tag);
        int z;
        z = 0;
        while (line_log.size() < from + len) step();
        for (int i = from; i < from + len; i++) if (line_log[i] != 1'b1) z++;
        chk(tag, z, 0);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (txd_empty !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        chk(tag, txd_empty, 1'b1);
    endtask

    // Mid-bit sampling receiver over the recorded line.
    task automatic decode(input int from, input int to,
                          output logic [7:0] got[$], output int bad);
        int i;
        logic [7:0] b;
        got = {};
        bad = 0;
        i = from;
        while (i + FR <= to) begin
            if (line_log[i] == 1'b0) begin
                b = 8'd0;
                for (int k = 0; k < 8; k++) b[k] = line_log[i + (k+1)*DIV + DIV/2];
                if (line_log[i + (NB-1)*DIV + DIV/2] != 1'b1) bad++;
`ifdef UART_TX_PARITY_EN
                if (line_log[i + 9*DIV + DIV/2] != ^b) bad++;
`endif
                got.push_back(b);
                i += FR;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        // Reset and idle
        step();
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_outputs", {ser_txd, txd_empty, txd_level, txd_busy},
                {1'b1, 1'b1, 4'd0, 1'b0});
        end

        // Single byte latency and framing
        n0 = now();
        load(8'hA5);
        chk("single_level_n1", txd_level, 1);
        chk("single_line_n1", ser_txd, 1'b1);
        step();
        chk("single_start_n2", ser_txd, 1'b0);
        exp_q = {8'hA5};
        frames_at(n0 + 2, exp_q, "single");
        while (now() < n0 + 1 + FR) step();
        chk("single_empty_last_stop", txd_empty, 1'b0);
        step();
        chk("single_empty_after", txd_empty, 1'b1);
        chk("single_line_after", ser_txd, 1'b1);

`ifdef UART_TX_PARITY_EN
        n0 = now();
        load(8'h07);
        exp_q = {8'h07};
        frames_at(n0 + 2, exp_q, "parity07");
        chk("parity07_bit", line_log[n0 + 2 + 9*DIV], 1'b1);
        chk("parity07_stop", line_log[n0 + 2 + 10*DIV], 1'b1);
        while (now() < n0 + 2 + FR) step();
        chk("parity07_empty", txd_empty, 1'b1);
`endif

        // Back-to-back and full: the first byte pops straight into the
        // shifter, so ten loads are needed to overflow a depth-8 FIFO.
        repeat (5) step();
        n0 = now();
        exp_q = {};
        for (int i = 0; i < 9; i++) begin
            load(8'(i));
            exp_q.push_back(8'(i));
        end
        chk("full_busy", txd_busy, 1'b1);
        chk("full_level", txd_level, 8);
        load(8'h09);
        chk("drop_level", txd_level, 8);
        chk("drop_busy", txd_busy, 1'b1);
        frames_at(n0 + 2, exp_q, "b2b");
        idle_for(n0 + 2 + 9*FR, 3*FR, "b2b_no_extra");
        wait_empty("b2b_drain");

        // Load on the exact pop cycle of a full FIFO
        repeat (3) step();
        n0 = now();
        exp_q = {};
        for (int i = 0; i < 9; i++) begin
            rb = 8'($urandom);
            load(rb);
            exp_q.push_back(rb);
        end
        p0 = n0 + 1 + FR;
        while (now() < p0) step();
        chk("pop_level_before", txd_level, 8);
        chk("pop_busy_before", txd_busy, 1'b1);
        txd_ld = 1'b1;
        din    = ~exp_q[0];
        step();
        chk("pop_level_after", txd_level, 7);
        chk("pop_busy_after", txd_busy, 1'b0);
        rb     = 8'($urandom);
        din    = rb;
        step();
        txd_ld = 1'b0;
        exp_q.push_back(rb);
        chk("late_level", txd_level, 8);
        chk("late_busy", txd_busy, 1'b1);
        frames_at(n0 + 2, exp_q, "simul");
        idle_for(n0 + 2 + 10*FR, 2*FR, "simul_no_extra");
        wait_empty("simul_drain");

        // Randomized bursts checked by decoding the line
        repeat (2) step();
        n0 = now();
        exp_q = {};
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                rb = 8'($urandom);
                load(rb);
                exp_q.push_back(rb);
                repeat ($urandom_range(0, 3)) step();
            end
            wait_empty($sformatf("rnd_drain%0d", b));
            repeat ($urandom_range(0, 9)) step();
        end
        decode(n0, line_log.size(), got_q, nbad);
        chk("rnd_count", got_q.size(), exp_q.size());
        chk("rnd_bad_stop_parity", nbad, 0);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("rnd_byte%0d", i), got_q[i], exp_q[i]);

        // Reset mid-frame during data bit 3 of 0xFF
        repeat (3) step();
        n0 = now();
        load(8'hFF);
        load(8'($urandom));
        load(8'($urandom));
        load(8'($urandom));
        guard = 0;
        while (now() < n0 + 2 + 4*DIV + 1 && guard < 100) begin
            step();
            guard++;
        end
        chk("rstmid_level_before", txd_level, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_line", ser_txd, 1'b1);
        chk("rstmid_level", txd_level, 0);
        chk("rstmid_busy", txd_busy, 1'b0);
        chk("rstmid_empty", txd_empty, 1'b1);
        idle_for(now(), 3*FR, "rstmid_no_frames");
        chk("rstmid_final_level", txd_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
